logic_unit_arbiter: RTL and testbench

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) among `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter grants one request at a time, sequences the operation through a registered execute stage, and returns the result with the requester's index on a single response channel that has back-pressure. It sits between the lab's requester blocks and the shared 32-bit logic datapath.

---
 rtl/logic_unit_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR)
//               among NREQ valid/ready requesters. One request is accepted
//               at a time, executed in a registered stage, and returned on
//               a single back-pressured response channel with its owner id.
//               Optional feature macro: LOGIC_ARB_ROUND_ROBIN_EN
//               (defined = round-robin grant, undefined = fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [2*NREQ-1:0]          req_op,
    input  logic [WIDTH*NREQ-1:0]      req_a,
    input  logic [WIDTH*NREQ-1:0]      req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(NREQ)-1:0]    rsp_id
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic             w_any;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_accept;

    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [1:0]       w_sel_op;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [IDW-1:0]   r_id;

    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;

    assign w_any    = |req_valid;
    assign w_accept = (r_state == S_IDLE) && w_any;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    // Last granted index; search begins one past it so that out of reset
    // (pointer = NREQ-1) requester 0 has top priority.
    logic [IDW-1:0] r_ptr;

    // Round-robin grant: pick the valid requester with the smallest
    // circular distance from (r_ptr + 1).
    always_comb begin
        int w_best;
        int w_dist;
        w_gnt_idx = '0;
        w_best    = NREQ;
        w_dist    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(r_ptr) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_gnt_idx = IDW'(i);
            end
        end
    end

    // Pointer moves only when a request is actually accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_gnt_idx;
        end
    end
`else
    // Fixed priority grant: the lowest valid index wins.
    always_comb begin
        logic w_found;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !w_found) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(i);
            end
        end
    end
`endif

    // Operand/opcode mux for the granted requester.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = OP_AND;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_a  = req_a[WIDTH*i +: WIDTH];
                w_sel_b  = req_b[WIDTH*i +: WIDTH];
                w_sel_op = req_op[2*i +: 2];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: one-hot ready in IDLE only, valid while in RESP.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept && (w_gnt_idx == IDW'(i));
        end
        rsp_valid = (r_state == S_RESP);
    end

    // Bitwise logic unit evaluated on the latched operands.
    always_comb begin
        case (r_op)
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_NOR:  w_result = ~(r_a | r_b);
            default: w_result = '0;
        endcase
    end

    // Capture the granted request, then register its result and owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_AND;
            r_id       <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= w_sel_a;
                r_b  <= w_sel_b;
                r_op <= w_sel_op;
                r_id <= w_gnt_idx;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data <= w_result;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Self-checking bench for logic_unit_arbiter (NREQ=4,
//               WIDTH=32). Follows LOGIC_ARB_ROUND_ROBIN_EN for the
//               expected contention order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [1:0]            rsp_id;

    int n_checks;
    int n_fail;
    int cyc;

    logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*id +: 2]    = op;
        req_a[WIDTH*id +: WIDTH] = a;
        req_b[WIDTH*id +: WIDTH] = b;
        req_valid[id]        = 1'b1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("grant_timeout", {31'd0, ok}, 32'd1);
    endtask

    // One complete transaction from IDLE with rsp_ready held high.
    task automatic run_vec(input vec_t v);
        present(v.id, v.op, v.a, v.b);
        #1;
        check("vec_req_ready", 32'(req_ready), 32'(1) << v.id);
        tick();
        req_valid = '0;
        #1;
        check("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("vec_exec_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        check("vec_rsp_data", rsp_data, v.exp);
        check("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        tick();
        check("vec_rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit          ok;
        int          exp_id;
        int          t_first;
        int          t_second;
        logic [31:0] held_data;

        vecs[0] = '{0, 2'b00, 32'h0000A5A5, 32'h00005A5A, 32'h00000000};
        vecs[1] = '{2, 2'b01, 32'h0000A5A5, 32'h00005A5A, 32'h0000FFFF};
        vecs[2] = '{2, 2'b10, 32'h0000A5A5, 32'h00005A5A, 32'h0000FFFF};
        vecs[3] = '{2, 2'b11, 32'h0000A5A5, 32'h00005A5A, 32'hFFFF0000};
        vecs[4] = '{1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000};
        vecs[5] = '{3, 2'b10, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h21524110};
        vecs[6] = '{1, 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[7] = '{3, 2'b01, 32'h12340000, 32'h00005678, 32'h12345678};

        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state.
        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check("idle_no_req_ready", 32'(req_ready), 32'd0);

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: req0 NOR held in RESP for 10 cycles while req1 waits.
        rsp_ready = 1'b0;
        present(0, 2'b11, 32'h0F0F0F0F, 32'h00FF00FF);
        #1;
        check("bp_req_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        present(1, 2'b00, 32'hFFFFFFFF, 32'h13579BDF);
        #1;
        check("bp_exec_req_ready", 32'(req_ready), 32'd0);
        tick();
        held_data = 32'hF000F000;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", rsp_data, held_data);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        check("bp_req1_data", rsp_data, 32'h13579BDF);
        check("bp_req1_id", 32'(rsp_id), 32'd1);
        tick();

        // Reset while in RESP (req2 served just before to move the pointer).
        present(2, 2'b01, 32'hAAAA0000, 32'h00005555);
        tick();
        req_valid = '0;
        tick();
        check("mr_rsp_valid_pre", 32'(rsp_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rsp_data", rsp_data, 32'd0);
        check("mr_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check("mr_idle_ready", 32'(req_ready), 32'd0);

        // Contention: all four valid, six grants.
        for (int r = 0; r < NREQ; r++) begin
            present(r, 2'b10, 32'(r), 32'h0000FF00);
        end
        for (int g = 0; g < 6; g++) begin
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
            exp_id = g % NREQ;
`else
            exp_id = 0;
`endif
            wait_grant(ok);
            check("ct_grant", 32'(req_ready), 32'(1) << exp_id);
            tick();
            if (g == 5) req_valid = '0;
            tick();
            check("ct_rsp_id", 32'(rsp_id), 32'(exp_id));
            check("ct_rsp_data", rsp_data, 32'(exp_id) ^ 32'h0000FF00);
            tick();
        end

        // Back-to-back from req3 with rsp_ready always high.
        present(3, 2'b00, 32'hFF00FF00, 32'h0FF00FF0);
        #1;
        wait_grant(ok);
        check("bb_grant1", 32'(req_ready), 32'h8);
        t_first = cyc;
        tick();
        present(3, 2'b10, 32'hFF00FF00, 32'h0FF00FF0);
        tick();
        check("bb_id1", 32'(rsp_id), 32'd3);
        check("bb_data1", rsp_data, 32'h0F000F00);
        tick();
        wait_grant(ok);
        check("bb_grant2", 32'(req_ready), 32'h8);
        t_second = cyc;
        check("bb_spacing", 32'(t_second - t_first), 32'd3);
        tick();
        req_valid = '0;
        tick();
        check("bb_id2", 32'(rsp_id), 32'd3);
        check("bb_data2", rsp_data, 32'hF0F0F0F0);
        tick();
        check("bb_done", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
